// File: rtl/ascon_tag_collector.sv
// Tag assembler and FIFO for the ASCON input path: packs bus-width tag beats into
// full tags, queues them, and presents the oldest one to the compare logic on demand.
package ascon_cfg;
    localparam logic [2:0] D_NONE = 3'd0;
    localparam logic [2:0] D_AD   = 3'd1;
    localparam logic [2:0] D_MSG  = 3'd2;
    localparam logic [2:0] D_TAG  = 3'd3;
    localparam logic [2:0] D_KEY  = 3'd4;
endpackage

module ascon_tag_collector #(
    parameter int         BUS_W    = 32,
    parameter int         TAG_W    = 128,
    parameter int         DEPTH    = 2,
    parameter logic [2:0] TAG_CODE = ascon_cfg::D_TAG
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       bd_valid_i,
    input  logic [2:0]                 bd_type_i,
    input  logic                       bd_ready_i,
    input  logic [BUS_W-1:0]           bd_i,
    input  logic                       pass_data_i,
    input  logic                       abort_i,
    input  logic                       clr_err_i,
    output logic                       tag_ready_o,
    output logic [TAG_W-1:0]           run_tag_o,
    output logic                       run_tag_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] tag_count_o,
    output logic                       partial_o,
    output logic                       underflow_o
);

    localparam int N      = TAG_W / BUS_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_OW = $clog2(DEPTH + 1);

    generate
        if (TAG_W % BUS_W != 0) begin : g_bad_ratio
            $error("ascon_tag_collector: TAG_W must be an integer multiple of BUS_W");
        end
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("ascon_tag_collector: DEPTH must be in 1..8");
        end
    endgenerate

    logic [TAG_W-1:0]  asm_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [TAG_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_OW-1:0] count;

    logic             empty;
    logic             full;
    logic             last_beat;
    logic             beat;
    logic             push;
    logic             pop;
    logic [TAG_W-1:0] asm_next;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_OW'(DEPTH));
    assign last_beat = (beat_cnt == CNT_W'(N - 1));

    // A same-cycle pop frees the slot the completing beat needs, so only stall without one.
    assign tag_ready_o = ~(full & last_beat & ~pass_data_i);

    assign beat     = bd_valid_i & bd_ready_i & tag_ready_o & (bd_type_i == TAG_CODE);
    assign push     = beat & last_beat & ~abort_i;
    assign pop      = pass_data_i & ~empty;
    assign asm_next = (asm_q << BUS_W) | TAG_W'(bd_i);

    assign tag_count_o = count;
    assign partial_o   = (beat_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            asm_q    <= '0;
            beat_cnt <= '0;
        end else if (abort_i) begin
            asm_q    <= '0;
            beat_cnt <= '0;
        end else if (beat) begin
            if (last_beat) begin
                asm_q    <= '0;
                beat_cnt <= '0;
            end else begin
                asm_q    <= asm_next;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the tag storage is reset along with the pointers, so a cleared collector
    // never exposes a stale tag, at the cost of reset fan-out to every storage bit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            run_tag_o       <= '0;
            run_tag_valid_o <= 1'b0;
            underflow_o     <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= asm_next;
                tail      <= next_ptr(tail);
            end

            if (pop) begin
                run_tag_o       <= mem[head];
                run_tag_valid_o <= 1'b1;
                head            <= next_ptr(head);
            end else if (pass_data_i) begin
                run_tag_o       <= '0;
                run_tag_valid_o <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_OW'(1);
                2'b01:   count <= count - CNT_OW'(1);
                default: count <= count;
            endcase

            if (clr_err_i) begin
                underflow_o <= 1'b0;
            end else if (pass_data_i && empty) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ascon_tag_collector.sv
// Directed bench for ascon_tag_collector: a vector table for the 32-bit instance plus
// hand sequences for asynchronous reset and a 64-bit bus instance.
module tb_ascon_tag_collector;

    localparam logic [2:0] TC = 3'd3;
    localparam logic [2:0] NT = 3'd1;

    logic         clk;
    logic         rst_n;
    logic         bd_valid;
    logic [2:0]   bd_type;
    logic         bd_ready;
    logic [31:0]  bd;
    logic [63:0]  bd64;
    logic         pass_data;
    logic         abort;
    logic         clr_err;

    logic         tag_ready;
    logic [127:0] run_tag;
    logic         run_tag_valid;
    logic [1:0]   tag_count;
    logic         partial;
    logic         underflow;

    logic         tag_ready64;
    logic [127:0] run_tag64;
    logic         run_tag_valid64;
    logic [1:0]   tag_count64;
    logic         partial64;
    logic         underflow64;

    int checks = 0;
    int errors = 0;

    ascon_tag_collector #(.BUS_W(32), .TAG_W(128), .DEPTH(2), .TAG_CODE(TC)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .bd_valid_i(bd_valid), .bd_type_i(bd_type),
        .bd_ready_i(bd_ready), .bd_i(bd), .pass_data_i(pass_data), .abort_i(abort),
        .clr_err_i(clr_err), .tag_ready_o(tag_ready), .run_tag_o(run_tag),
        .run_tag_valid_o(run_tag_valid), .tag_count_o(tag_count), .partial_o(partial),
        .underflow_o(underflow)
    );

    ascon_tag_collector #(.BUS_W(64), .TAG_W(128), .DEPTH(2), .TAG_CODE(TC)) u_dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .bd_valid_i(bd_valid), .bd_type_i(bd_type),
        .bd_ready_i(bd_ready), .bd_i(bd64), .pass_data_i(pass_data), .abort_i(abort),
        .clr_err_i(clr_err), .tag_ready_o(tag_ready64), .run_tag_o(run_tag64),
        .run_tag_valid_o(run_tag_valid64), .tag_count_o(tag_count64), .partial_o(partial64),
        .underflow_o(underflow64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [2:0]   typ;
        logic         rdy;
        logic [31:0]  data;
        logic         pass;
        logic         abrt;
        logic         clr;
        logic         e_ready;
        logic [1:0]   e_count;
        logic         e_partial;
        logic [127:0] e_run;
        logic         e_rv;
        logic         e_uf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] T1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] TA = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    localparam logic [127:0] TB = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [127:0] TCC = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] T4 = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] T5 = 128'h00000005_00000006_00000007_00000008;
    localparam logic [127:0] T6 = 128'h00000009_0000000A_0000000B_0000000C;
    localparam logic [127:0] TX = 128'h00000051_00000052_00000053_00000054;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic valid, input logic [2:0] typ, input logic rdy,
                       input logic [31:0] data, input logic pass, input logic abrt,
                       input logic clr, input logic e_ready, input logic [1:0] e_count,
                       input logic e_partial, input logic [127:0] e_run, input logic e_rv,
                       input logic e_uf);
        vec_t v;
        v.valid = valid; v.typ = typ; v.rdy = rdy; v.data = data;
        v.pass = pass; v.abrt = abrt; v.clr = clr;
        v.e_ready = e_ready; v.e_count = e_count; v.e_partial = e_partial;
        v.e_run = e_run; v.e_rv = e_rv; v.e_uf = e_uf;
        vecs.push_back(v);
    endtask

    // Shorthand for a plain accepted tag beat.
    task automatic beat(input logic [31:0] d, input logic [1:0] cnt, input logic part,
                        input logic [127:0] run, input logic rv, input logic uf);
        add(1, TC, 1, d, 0, 0, 0, 1, cnt, part, run, rv, uf);
    endtask

    task automatic idle_inputs();
        bd_valid = 0; bd_type = 3'd0; bd_ready = 1; bd = '0; bd64 = '0;
        pass_data = 0; abort = 0; clr_err = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // Scenario 1: one tag, then pop.
        beat(32'h11111111, 0, 1, 0, 0, 0);
        beat(32'h22222222, 0, 1, 0, 0, 0);
        beat(32'h33333333, 0, 1, 0, 0, 0);
        beat(32'h44444444, 1, 0, 0, 0, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, T1, 1, 0);
        // Scenario 3: underflow, hold, clear.
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, TC, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, TC, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // Scenario 2: fill FIFO, backpressure on the completing beat, pop releases it.
        beat(32'hA0A0A0A0, 0, 1, 0, 0, 0);
        beat(32'hA1A1A1A1, 0, 1, 0, 0, 0);
        beat(32'hA2A2A2A2, 0, 1, 0, 0, 0);
        beat(32'hA3A3A3A3, 1, 0, 0, 0, 0);
        beat(32'hB0B0B0B0, 1, 1, 0, 0, 0);
        beat(32'hB1B1B1B1, 1, 1, 0, 0, 0);
        beat(32'hB2B2B2B2, 1, 1, 0, 0, 0);
        beat(32'hB3B3B3B3, 2, 0, 0, 0, 0);
        beat(32'hC0C0C0C0, 2, 1, 0, 0, 0);
        beat(32'hC1C1C1C1, 2, 1, 0, 0, 0);
        beat(32'hC2C2C2C2, 2, 1, 0, 0, 0);
        add(1, TC, 1, 32'hC3C3C3C3, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        add(1, TC, 1, 32'hC3C3C3C3, 1, 0, 0, 1, 2, 0, TA, 1, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 1, 0, TB, 1, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, TCC, 1, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, TC, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // Scenario 4: abort wins over a same-cycle beat and discards the partial tag.
        beat(32'hDEADBEEF, 0, 1, 0, 0, 0);
        beat(32'hCAFEF00D, 0, 1, 0, 0, 0);
        add(1, TC, 1, 32'h99999999, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        beat(32'h00000001, 0, 1, 0, 0, 0);
        beat(32'h00000002, 0, 1, 0, 0, 0);
        beat(32'h00000003, 0, 1, 0, 0, 0);
        beat(32'h00000004, 1, 0, 0, 0, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, T4, 1, 0);
        // Scenario 5: non-tag beat and unready beat are ignored.
        beat(32'h00000005, 0, 1, T4, 1, 0);
        add(1, NT, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, T4, 1, 0);
        beat(32'h00000006, 0, 1, T4, 1, 0);
        add(1, TC, 0, 32'hEEEEEEEE, 0, 0, 0, 1, 0, 1, T4, 1, 0);
        beat(32'h00000007, 0, 1, T4, 1, 0);
        beat(32'h00000008, 1, 0, T4, 1, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, T5, 1, 0);
        // Push into an empty FIFO with a same-cycle pop: underflow, tag stays queued.
        beat(32'h00000009, 0, 1, T5, 1, 0);
        beat(32'h0000000A, 0, 1, T5, 1, 0);
        beat(32'h0000000B, 0, 1, T5, 1, 0);
        add(1, TC, 1, 32'h0000000C, 1, 0, 0, 1, 1, 0, 0, 0, 1);
        add(0, TC, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, T6, 1, 0);
        // Build up state ahead of the asynchronous reset check.
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        beat(32'h00000051, 0, 1, 0, 0, 1);
        beat(32'h00000052, 0, 1, 0, 0, 1);
        beat(32'h00000053, 0, 1, 0, 0, 1);
        beat(32'h00000054, 1, 0, 0, 0, 1);
        add(0, TC, 1, 0, 1, 0, 0, 1, 0, 0, TX, 1, 1);
        beat(32'h00000061, 0, 1, TX, 1, 1);
        beat(32'h00000062, 0, 1, TX, 1, 1);
        beat(32'h00000063, 0, 1, TX, 1, 1);
        beat(32'h00000064, 1, 0, TX, 1, 1);
        beat(32'h00000071, 1, 1, TX, 1, 1);
        beat(32'h00000072, 1, 1, TX, 1, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_ready", 128'(tag_ready), 128'(1'b1));
        check("reset_count", 128'(tag_count), 128'(2'd0));
        check("reset_partial", 128'(partial), 128'(1'b0));
        check("reset_run", run_tag, 128'd0);
        check("reset_rv", 128'(run_tag_valid), 128'(1'b0));
        check("reset_uf", 128'(underflow), 128'(1'b0));

        foreach (vecs[i]) begin
            @(negedge clk);
            bd_valid = vecs[i].valid; bd_type = vecs[i].typ; bd_ready = vecs[i].rdy;
            bd = vecs[i].data; pass_data = vecs[i].pass; abort = vecs[i].abrt;
            clr_err = vecs[i].clr;
            #1;
            check($sformatf("v%0d_ready", i), 128'(tag_ready), 128'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), 128'(tag_count), 128'(vecs[i].e_count));
            check($sformatf("v%0d_partial", i), 128'(partial), 128'(vecs[i].e_partial));
            check($sformatf("v%0d_run", i), run_tag, vecs[i].e_run);
            check($sformatf("v%0d_rv", i), 128'(run_tag_valid), 128'(vecs[i].e_rv));
            check($sformatf("v%0d_uf", i), 128'(underflow), 128'(vecs[i].e_uf));
        end

        // Scenario 6a: asynchronous reset mid-cycle clears everything immediately.
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_ready", 128'(tag_ready), 128'(1'b1));
        check("areset_count", 128'(tag_count), 128'(2'd0));
        check("areset_partial", 128'(partial), 128'(1'b0));
        check("areset_run", run_tag, 128'd0);
        check("areset_rv", 128'(run_tag_valid), 128'(1'b0));
        check("areset_uf", 128'(underflow), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 6b: 64-bit bus, two beats form a tag.
        @(negedge clk);
        bd_valid = 1; bd_type = TC; bd64 = 64'h11111111_22222222;
        @(posedge clk);
        #1;
        check("b64_partial1", 128'(partial64), 128'(1'b1));
        check("b64_count1", 128'(tag_count64), 128'(2'd0));
        @(negedge clk);
        bd64 = 64'h33333333_44444444;
        @(posedge clk);
        #1;
        check("b64_count2", 128'(tag_count64), 128'(2'd1));
        check("b64_partial2", 128'(partial64), 128'(1'b0));
        @(negedge clk);
        idle_inputs();
        pass_data = 1;
        @(posedge clk);
        #1;
        check("b64_run", run_tag64, T1);
        check("b64_rv", 128'(run_tag_valid64), 128'(1'b1));
        check("b64_count3", 128'(tag_count64), 128'(2'd0));
        @(negedge clk);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
